bcd_subtractor: RTL and testbench



---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_subtractor.sv | 21 ++
 rtl/bcd_subtractor.sv | 144 ++++++++++++++
 tb/tb_bcd_subtractor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD arithmetic blocks.
package bcd_pkg;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned BCD_RADIX = 10;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_subtractor.sv
// One-digit BCD subtract with borrow: diff = a - b - bin, wrapped into 0..9 on borrow.
module bcd_digit_subtractor
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [DIGIT_W:0] raw;

  // raw is a 5-bit two's-complement value in -16..15; bit 4 is the sign
  always_comb begin
    raw  = (DIGIT_W+1)'({1'b0, a}) - (DIGIT_W+1)'({1'b0, b}) - (DIGIT_W+1)'(bin);
    bout = raw[DIGIT_W];
    diff = raw[DIGIT_W] ? DIGIT_W'(raw + (DIGIT_W+1)'(BCD_RADIX)) : raw[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_subtractor.sv
// Digit-serial packed-BCD subtractor (arg1 - arg2), LSD first, one digit per clock.
// Define BCD_SUB_SIGNED_EN to return negative differences as magnitude plus sign flag.
module bcd_subtractor
  import bcd_pkg::*;
#(
  parameter int unsigned argWidth = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [argWidth-1:0] arg1,
  input  logic [argWidth-1:0] arg2,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                borrow,
  output logic                negative,
  output logic [argWidth-1:0] result
);

  localparam int unsigned W     = argWidth;
  localparam int unsigned N     = argWidth / DIGIT_W;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     a_sr, a_nxt, b_sr, b_nxt, acc, acc_nxt, acc_shift, result_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bin, bin_nxt, busy_nxt, done_nxt, borrow_nxt, negative_nxt;
  bcd_digit_t       diff;
  logic             bout;

  bcd_digit_subtractor u_digit (
    .a    (a_sr[DIGIT_W-1:0]),
    .b    (b_sr[DIGIT_W-1:0]),
    .bin  (bin),
    .diff (diff),
    .bout (bout)
  );

  // New digit enters at the MSB; after N shifts the first digit sits at the LSB
  assign acc_shift = W'({diff, acc} >> DIGIT_W);

  always_comb begin
    state_nxt    = state;
    a_nxt        = a_sr;
    b_nxt        = b_sr;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    bin_nxt      = bin;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    borrow_nxt   = borrow;
    negative_nxt = negative;
    result_nxt   = result;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SUB;
          a_nxt     = arg1;
          b_nxt     = arg2;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          bin_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      SUB: begin
        a_nxt   = a_sr >> DIGIT_W;
        b_nxt   = b_sr >> DIGIT_W;
        acc_nxt = acc_shift;
        bin_nxt = bout;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST) begin
`ifdef BCD_SUB_SIGNED_EN
          // Negative difference: second pass computes 0 - acc to recover the magnitude
          if (bout) begin
            state_nxt = FIX;
            a_nxt     = '0;
            b_nxt     = acc_shift;
            bin_nxt   = 1'b0;
            cnt_nxt   = '0;
          end else begin
`else
          begin
`endif
            state_nxt    = IDLE;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
            result_nxt   = acc_shift;
            borrow_nxt   = bout;
            negative_nxt = 1'b0;
          end
        end
      end
`ifdef BCD_SUB_SIGNED_EN
      FIX: begin
        a_nxt   = a_sr >> DIGIT_W;
        b_nxt   = b_sr >> DIGIT_W;
        acc_nxt = acc_shift;
        bin_nxt = bout;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          state_nxt    = IDLE;
          busy_nxt     = 1'b0;
          done_nxt     = 1'b1;
          result_nxt   = acc_shift;
          borrow_nxt   = 1'b1;
          negative_nxt = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      cnt      <= '0;
      bin      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      borrow   <= 1'b0;
      negative <= 1'b0;
      result   <= '0;
    end else begin
      state    <= state_nxt;
      a_sr     <= a_nxt;
      b_sr     <= b_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      bin      <= bin_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      borrow   <= borrow_nxt;
      negative <= negative_nxt;
      result   <= result_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_subtractor.sv
// Self-checking bench for bcd_subtractor; expectations follow BCD_SUB_SIGNED_EN.
module tb_bcd_subtractor;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         clk, resetn, start, busy, done, borrow, negative;
  logic [W-1:0] arg1, arg2, result;
  int           passed = 0;
  int           total  = 0;

  bcd_subtractor #(.argWidth(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .arg1     (arg1),
    .arg2     (arg2),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .borrow   (borrow),
    .negative (negative),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: decimal integer arithmetic on the operand values
  function automatic longint bcd_val(input logic [W-1:0] x);
    longint v = 0;
    for (int i = N - 1; i >= 0; i--) v = v * 10 + longint'(x[i*4 +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] er, output logic eb, output logic en,
                       output int el);
    longint d = bcd_val(a) - bcd_val(b);
    longint p = 1;
    for (int i = 0; i < N; i++) p = p * 10;
    el = N; eb = 1'b0; en = 1'b0; er = to_bcd(d);
    if (d < 0) begin
      eb = 1'b1;
`ifdef BCD_SUB_SIGNED_EN
      en = 1'b1; er = to_bcd(-d); el = 2 * N;
`else
      er = to_bcd(d + p);
`endif
    end
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); arg1 = a; arg2 = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns at the negedge where busy is first low (the done cycle)
  task automatic wait_done(output logic [W-1:0] res, output logic bor, output logic neg,
                           output logic dn, output int lat, output int early, output logic to);
    lat = 0; early = 0; to = 1'b1;
    for (int i = 0; i < 64 && to; i++) begin
      if (busy) begin
        lat++;
        if (done) early++;
        @(negedge clk);
      end else to = 1'b0;
    end
    res = result; bor = borrow; neg = negative; dn = done;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; arg1 = '0; arg2 = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (borrow !== 1'b0) $display("FAIL reset_borrow got %b want 0", borrow); else passed++;
    total++; if (negative !== 1'b0) $display("FAIL reset_negative got %b want 0", negative); else passed++;
    total++; if (result !== '0) $display("FAIL reset_result got %h want 0", result); else passed++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic [W-1:0] er, r;
    logic eb, en, b, n, dn, to;
    int el, lat, early;
    va = '{16'h4321, 16'h1234, 16'h0000, 16'h5555, 16'h1000};
    vb = '{16'h1234, 16'h4321, 16'h0001, 16'h5555, 16'h0001};
    for (int i = 0; i < 5; i++) begin
      model(va[i], vb[i], er, eb, en, el);
      issue(va[i], vb[i]);
      wait_done(r, b, n, dn, lat, early, to);
      total++; if (to) $display("FAIL dir%0d_timeout busy never dropped", i); else passed++;
      total++; if (r !== er) $display("FAIL dir%0d_result %h-%h got %h want %h", i, va[i], vb[i], r, er); else passed++;
      total++; if (b !== eb) $display("FAIL dir%0d_borrow got %b want %b", i, b, eb); else passed++;
      total++; if (n !== en) $display("FAIL dir%0d_negative got %b want %b", i, n, en); else passed++;
      total++; if (lat !== el) $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, lat, el); else passed++;
      total++; if (dn !== 1'b1 || early !== 0) $display("FAIL dir%0d_done got %b early %0d want 1 early 0", i, dn, early); else passed++;
      @(negedge clk);
      total++; if (done !== 1'b0) $display("FAIL dir%0d_done_width got %b want 0", i, done); else passed++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] er, r;
    logic eb, en, b, n, dn, to;
    int el, lat, early;
    model(16'h8765, 16'h0123, er, eb, en, el);
    issue(16'h8765, 16'h0123);
    @(negedge clk); arg1 = 16'h0001; arg2 = 16'h9999; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(r, b, n, dn, lat, early, to);
    total++; if (to) $display("FAIL ignore_timeout busy never dropped"); else passed++;
    total++; if (r !== er || b !== eb || n !== en) $display("FAIL ignore_result got %h/%b/%b want %h/%b/%b", r, b, n, er, eb, en); else passed++;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL ignore_restart busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] er, r;
    logic eb, en, b, n, dn, to;
    int el, lat, early;
    model(16'h1234, 16'h4321, er, eb, en, el);
    issue(16'h1234, 16'h4321);
    wait_done(r, b, n, dn, lat, early, to);
    total++; if (to || r !== er || b !== eb || n !== en) $display("FAIL b2b_first got %h/%b/%b to %b want %h/%b/%b", r, b, n, to, er, eb, en); else passed++;
    arg1 = 16'h9876; arg2 = 16'h5432; start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL b2b_no_gap busy got %b want 1", busy); else passed++;
    model(16'h9876, 16'h5432, er, eb, en, el);
    wait_done(r, b, n, dn, lat, early, to);
    total++; if (to || r !== er || b !== eb || n !== en) $display("FAIL b2b_second got %h/%b/%b to %b want %h/%b/%b", r, b, n, to, er, eb, en); else passed++;
    total++; if (lat !== el) $display("FAIL b2b_busy_cycles got %0d want %0d", lat, el); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] er, r;
    logic eb, en, b, n, dn, to;
    int el, lat, early, dcount;
    issue(16'h4321, 16'h1234);
    @(negedge clk); resetn = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl busy %b done %b want 0 0", busy, done); else passed++;
    total++; if (result !== '0 || borrow !== 1'b0 || negative !== 1'b0) $display("FAIL midrst_outputs got %h/%b/%b want 0/0/0", result, borrow, negative); else passed++;
    @(negedge clk); resetn = 1'b1;
    dcount = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    total++; if (dcount !== 0) $display("FAIL midrst_no_done got %0d active cycles want 0", dcount); else passed++;
    model(16'h9000, 16'h0001, er, eb, en, el);
    issue(16'h9000, 16'h0001);
    wait_done(r, b, n, dn, lat, early, to);
    total++; if (to || r !== 16'h8999 || r !== er) $display("FAIL midrst_after got %h to %b want 8999", r, to); else passed++;
    total++; if (b !== 1'b0 || n !== 1'b0) $display("FAIL midrst_after_flags got %b/%b want 0/0", b, n); else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, bb, er, r;
    logic eb, en, b, n, dn, to;
    int el, lat, early;
    for (int i = 0; i < 24; i++) begin
      a = rand_bcd(); bb = rand_bcd();
      model(a, bb, er, eb, en, el);
      issue(a, bb);
      wait_done(r, b, n, dn, lat, early, to);
      total++; if (to) $display("FAIL rnd%0d_timeout busy never dropped", i); else passed++;
      total++; if (r !== er) $display("FAIL rnd%0d_result %h-%h got %h want %h", i, a, bb, r, er); else passed++;
      total++; if (b !== eb || n !== en) $display("FAIL rnd%0d_flags got %b/%b want %b/%b", i, b, n, eb, en); else passed++;
      total++; if (lat !== el || dn !== 1'b1) $display("FAIL rnd%0d_timing lat %0d done %b want %0d 1", i, lat, dn, el); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
